// File: rtl/creg_irq_aggregator.sv
// creg_irq_aggregator: latches per-source irq edges as pending, masks them with EN, and
// priority-encodes them onto a single level irq_o. Software services sources over APB with a
// CLAIM read and a COMPLETE write. Per-source err pulses are latched sticky in ERR.
// Optional build macro: CREG_IRQ_LEVEL_EN adds a TRIG register at offset 6, which selects
// level-sensitive sources.
module creg_irq_aggregator #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  input  logic               pwrite_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               psuberr_o,
  input  logic [NUM_SRC-1:0] src_irq_i,
  input  logic [NUM_SRC-1:0] src_err_i,
  output logic               irq_o
);

  localparam logic [3:0] OffPend     = 4'd0;
  localparam logic [3:0] OffEn       = 4'd1;
  localparam logic [3:0] OffClaim    = 4'd2;
  localparam logic [3:0] OffComplete = 4'd3;
  localparam logic [3:0] OffInsrv    = 4'd4;
  localparam logic [3:0] OffErr      = 4'd5;
  localparam logic [3:0] OffTrig     = 4'd6;

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] insrv_q, insrv_d;
  logic [NUM_SRC-1:0] err_q, err_d;
  logic [NUM_SRC-1:0] src_q, src_d;    // registered src_irq_i
  logic [NUM_SRC-1:0] hist_q, hist_d;  // previous registered value, for edge detect
  logic [31:0]        prdata_q, prdata_d;
  logic [NUM_SRC-1:0] trig;

  logic               wr_en, rd_en;
  logic [3:0]         offset;
  logic [NUM_SRC-1:0] elig, win_oh, claim_oh, cmp_oh, rise;
  logic [NUM_SRC-1:0] pend_w1c, err_w1c, pend_edge;
  logic [4:0]         win_id;
  logic [31:0]        rd_val;
  logic               unused_ok;

  assign pready_o  = 1'b1;
  assign psuberr_o = 1'b0;
  assign prdata_o  = prdata_q;
  assign unused_ok = ^{paddr_i[31:6], paddr_i[1:0], pwdata_i};

`ifdef CREG_IRQ_LEVEL_EN
  logic [NUM_SRC-1:0] trig_q, trig_d;

  // TRIG register: 1 selects level-sensitive behaviour for that source.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) trig_q <= '0;
    else       trig_q <= trig_d;
  end

  // TRIG next state: plain RW at offset 6.
  always_comb begin
    trig_d = trig_q;
    if (wr_en && offset == OffTrig) trig_d = pwdata_i[NUM_SRC-1:0];
  end

  assign trig = trig_q;
`else
  assign trig = '0;
`endif

  // APB decode, eligibility and lowest-index priority encode.
  always_comb begin
    wr_en  = psel_i & penable_i & pwrite_i;
    rd_en  = psel_i & ~penable_i & ~pwrite_i;
    offset = paddr_i[5:2];
    elig   = pend_q & en_q & ~insrv_q;
    win_oh = '0;
    win_id = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = 5'(i);
      end
    end
    claim_oh = (rd_en && offset == OffClaim) ? win_oh : '0;
  end

  assign irq_o = |elig;

  // Next state for pending, enable, in-service and error state; set always wins over clear.
  always_comb begin
    src_d     = src_irq_i;
    hist_d    = src_q;
    rise      = src_q & ~hist_q;
    pend_w1c  = (wr_en && offset == OffPend) ? pwdata_i[NUM_SRC-1:0] : '0;
    err_w1c   = (wr_en && offset == OffErr) ? pwdata_i[NUM_SRC-1:0] : '0;
    pend_edge = (pend_q & ~pend_w1c & ~claim_oh) | rise;
    // Level sources simply mirror the registered input; W1C and CLAIM cannot clear them.
    pend_d    = (pend_edge & ~trig) | (src_q & trig);
    en_d      = en_q;
    if (wr_en && offset == OffEn) en_d = pwdata_i[NUM_SRC-1:0];
    // Ids outside the source range match no bit and are dropped.
    cmp_oh = '0;
    if (wr_en && offset == OffComplete) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (pwdata_i[4:0] == 5'(i)) cmp_oh[i] = 1'b1;
      end
    end
    insrv_d = (insrv_q & ~cmp_oh) | claim_oh;
    err_d   = (err_q & ~err_w1c) | src_err_i;
  end

  // Read mux; data is only presented for the cycle after a setup-phase read.
  always_comb begin
    rd_val = '0;
    case (offset)
      OffPend:  rd_val = 32'(pend_q);
      OffEn:    rd_val = 32'(en_q);
      OffClaim: rd_val = (|elig) ? {1'b1, 26'b0, win_id} : 32'h0;
      OffInsrv: rd_val = 32'(insrv_q);
      OffErr:   rd_val = 32'(err_q);
`ifdef CREG_IRQ_LEVEL_EN
      OffTrig:  rd_val = 32'(trig);
`endif
      default:  rd_val = '0;
    endcase
    prdata_d = rd_en ? rd_val : 32'h0;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q   <= '0;
      en_q     <= '0;
      insrv_q  <= '0;
      err_q    <= '0;
      src_q    <= '0;
      hist_q   <= '0;
      prdata_q <= '0;
    end else begin
      pend_q   <= pend_d;
      en_q     <= en_d;
      insrv_q  <= insrv_d;
      err_q    <= err_d;
      src_q    <= src_d;
      hist_q   <= hist_d;
      prdata_q <= prdata_d;
    end
  end

endmodule
